// File: rtl/axi_reg_slice.sv
// AXI4 register slice: five independent per-channel slices (AW, W, B, AR, R), each selectable
// as bypass, forward register, or fully registered two-entry skid buffer.
module axi_reg_slice #(
    parameter int unsigned ID_W    = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned USER_W  = 1,
    parameter int unsigned AW_MODE = 2,
    parameter int unsigned W_MODE  = 2,
    parameter int unsigned B_MODE  = 2,
    parameter int unsigned AR_MODE = 2,
    parameter int unsigned R_MODE  = 2,
    localparam int unsigned AWP    = ID_W + ADDR_W + 30 + USER_W,
    localparam int unsigned WP     = ID_W + DATA_W + DATA_W / 8 + USER_W + 1,
    localparam int unsigned BP     = ID_W + 2 + USER_W,
    localparam int unsigned RP     = ID_W + DATA_W + 2 + USER_W + 1
) (
    input  logic           aclk,
    input  logic           aresetn,

    input  logic           s_aw_valid,
    output logic           s_aw_ready,
    input  logic [AWP-1:0] s_aw_pld,
    output logic           m_aw_valid,
    input  logic           m_aw_ready,
    output logic [AWP-1:0] m_aw_pld,

    input  logic           s_w_valid,
    output logic           s_w_ready,
    input  logic [WP-1:0]  s_w_pld,
    output logic           m_w_valid,
    input  logic           m_w_ready,
    output logic [WP-1:0]  m_w_pld,

    input  logic           m_b_valid,
    output logic           m_b_ready,
    input  logic [BP-1:0]  m_b_pld,
    output logic           s_b_valid,
    input  logic           s_b_ready,
    output logic [BP-1:0]  s_b_pld,

    input  logic           s_ar_valid,
    output logic           s_ar_ready,
    input  logic [AWP-1:0] s_ar_pld,
    output logic           m_ar_valid,
    input  logic           m_ar_ready,
    output logic [AWP-1:0] m_ar_pld,

    input  logic           m_r_valid,
    output logic           m_r_ready,
    input  logic [RP-1:0]  m_r_pld,
    output logic           s_r_valid,
    input  logic           s_r_ready,
    output logic [RP-1:0]  s_r_pld
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} slot_e;

    // Holds every registered slice not-ready for one cycle after reset release.
    logic rst_done_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rst_done_q <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
        end
    end

    // Channel index: 0=AW, 1=W, 2=B, 3=AR, 4=R.
    for (genvar c = 0; c < 5; c++) begin : g_ch
        localparam int unsigned PW   = (c == 0 || c == 3) ? AWP :
                                       (c == 1) ? WP : (c == 2) ? BP : RP;
        localparam int unsigned MODE = (c == 0) ? AW_MODE : (c == 1) ? W_MODE :
                                       (c == 2) ? B_MODE : (c == 3) ? AR_MODE : R_MODE;

        logic          in_valid;
        logic          in_ready;
        logic [PW-1:0] in_pld;
        logic          out_valid;
        logic          out_ready;
        logic [PW-1:0] out_pld;

        if (c == 0) begin : g_map
            assign in_valid   = s_aw_valid;
            assign in_pld     = s_aw_pld;
            assign s_aw_ready = in_ready;
            assign m_aw_valid = out_valid;
            assign m_aw_pld   = out_pld;
            assign out_ready  = m_aw_ready;
        end else if (c == 1) begin : g_map
            assign in_valid   = s_w_valid;
            assign in_pld     = s_w_pld;
            assign s_w_ready  = in_ready;
            assign m_w_valid  = out_valid;
            assign m_w_pld    = out_pld;
            assign out_ready  = m_w_ready;
        end else if (c == 2) begin : g_map
            assign in_valid   = m_b_valid;
            assign in_pld     = m_b_pld;
            assign m_b_ready  = in_ready;
            assign s_b_valid  = out_valid;
            assign s_b_pld    = out_pld;
            assign out_ready  = s_b_ready;
        end else if (c == 3) begin : g_map
            assign in_valid   = s_ar_valid;
            assign in_pld     = s_ar_pld;
            assign s_ar_ready = in_ready;
            assign m_ar_valid = out_valid;
            assign m_ar_pld   = out_pld;
            assign out_ready  = m_ar_ready;
        end else begin : g_map
            assign in_valid   = m_r_valid;
            assign in_pld     = m_r_pld;
            assign m_r_ready  = in_ready;
            assign s_r_valid  = out_valid;
            assign s_r_pld    = out_pld;
            assign out_ready  = s_r_ready;
        end

        if (MODE == 0) begin : g_bypass
            assign out_valid = in_valid;
            assign out_pld   = in_pld;
            assign in_ready  = out_ready;
        end else if (MODE == 1) begin : g_fwd
            logic          valid_q;
            logic [PW-1:0] pld_q;

            assign in_ready  = rst_done_q && (!valid_q || out_ready);
            assign out_valid = valid_q;
            assign out_pld   = pld_q;

            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    valid_q <= 1'b0;
                end else if (in_ready) begin
                    valid_q <= in_valid;
                end
            end

            always_ff @(posedge aclk) begin
                if (in_ready && in_valid) begin
                    pld_q <= in_pld;
                end
            end
        end else if (MODE == 2) begin : g_full
            slot_e         state_q;
            slot_e         state_d;
            logic          ready_q;
            logic [PW-1:0] main_q;
            logic [PW-1:0] skid_q;
            logic          in_hs;
            logic          out_hs;
            logic          main_load;
            logic          main_from_skid;
            logic          skid_load;

            assign in_ready  = ready_q;
            assign out_valid = (state_q != StEmpty);
            assign out_pld   = main_q;
            assign in_hs     = in_valid && ready_q;
            assign out_hs    = out_valid && out_ready;

            always_comb begin
                state_d        = state_q;
                main_load      = 1'b0;
                main_from_skid = 1'b0;
                skid_load      = 1'b0;
                unique case (state_q)
                    StEmpty: begin
                        if (in_hs) begin
                            state_d   = StOne;
                            main_load = 1'b1;
                        end
                    end
                    StOne: begin
                        if (in_hs && !out_hs) begin
                            state_d   = StTwo;
                            skid_load = 1'b1;
                        end else if (!in_hs && out_hs) begin
                            state_d   = StEmpty;
                        end else if (in_hs && out_hs) begin
                            main_load = 1'b1;
                        end
                    end
                    StTwo: begin
                        if (out_hs) begin
                            state_d        = StOne;
                            main_from_skid = 1'b1;
                        end
                    end
                    default: state_d = StEmpty;
                endcase
            end

            // Ready is precomputed from the next state so it comes straight off a flop.
            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    state_q <= StEmpty;
                    ready_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    ready_q <= (state_d != StTwo);
                end
            end

            always_ff @(posedge aclk) begin
                if (main_load) begin
                    main_q <= in_pld;
                end else if (main_from_skid) begin
                    main_q <= skid_q;
                end
                if (skid_load) begin
                    skid_q <= in_pld;
                end
            end
        end else begin : g_bad_mode
            $error("axi_reg_slice: channel %0d has unsupported mode %0d", c, MODE);
        end
    end

endmodule

// File: tb/tb_axi_reg_slice.sv
// Directed bench for axi_reg_slice with AW bypass, AR forward and W/B/R full slices.
module tb_axi_reg_slice;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned USER_W = 1;
    localparam int unsigned AWP    = ID_W + ADDR_W + 30 + USER_W;
    localparam int unsigned WP     = ID_W + DATA_W + DATA_W / 8 + USER_W + 1;
    localparam int unsigned BP     = ID_W + 2 + USER_W;
    localparam int unsigned RP     = ID_W + DATA_W + 2 + USER_W + 1;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic           s_aw_valid, s_aw_ready, m_aw_valid, m_aw_ready;
    logic [AWP-1:0] s_aw_pld, m_aw_pld;
    logic           s_w_valid, s_w_ready, m_w_valid, m_w_ready;
    logic [WP-1:0]  s_w_pld, m_w_pld;
    logic           m_b_valid, m_b_ready, s_b_valid, s_b_ready;
    logic [BP-1:0]  m_b_pld, s_b_pld;
    logic           s_ar_valid, s_ar_ready, m_ar_valid, m_ar_ready;
    logic [AWP-1:0] s_ar_pld, m_ar_pld;
    logic           m_r_valid, m_r_ready, s_r_valid, s_r_ready;
    logic [RP-1:0]  m_r_pld, s_r_pld;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    axi_reg_slice #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .USER_W(USER_W),
        .AW_MODE(0), .W_MODE(2), .B_MODE(2), .AR_MODE(1), .R_MODE(2)
    ) u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_pld(s_aw_pld),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_pld(m_aw_pld),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_pld(s_w_pld),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_pld(m_w_pld),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_pld(m_b_pld),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_pld(s_b_pld),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_pld(s_ar_pld),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_pld(m_ar_pld),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_pld(m_r_pld),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_pld(s_r_pld)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic smp();
        @(negedge aclk);
    endtask

    task automatic aw_vec(input string tag, input logic v, input logic [AWP-1:0] p,
                          input logic r);
        s_aw_valid = v;
        s_aw_pld   = p;
        m_aw_ready = r;
        #1;
        chk({tag, "_valid"}, m_aw_valid, v);
        chk({tag, "_pld"}, m_aw_pld, p);
        chk({tag, "_ready"}, s_aw_ready, r);
    endtask

    function automatic logic [WP-1:0] wbeat(input int i);
        return {4'(i), 64'hA5A5_0000_0000_0000 | 64'(i), 8'hFF, 1'b1, (i == 15)};
    endfunction

    function automatic logic [RP-1:0] rbeat(input int i);
        return {4'h3, 64'(i + 1) * 64'h1111, 2'b00, 1'b0, (i == 5)};
    endfunction

    function automatic logic [AWP-1:0] arbeat(input logic [31:0] addr);
        return {4'h1, addr, 8'd3, 3'd3, 2'd1, 2'd0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0};
    endfunction

    int   exp_oidx [12] = '{-1, 0, 1, 1, 1, 1, 2, 3, 4, 5, -1, -1};
    logic exp_mrdy [12] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    logic sr_rdy   [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    int   si;

    initial begin
        aresetn    = 1'b0;
        s_aw_valid = 1'b0; s_aw_pld = '0; m_aw_ready = 1'b0;
        s_w_valid  = 1'b0; s_w_pld  = '0; m_w_ready  = 1'b0;
        m_b_valid  = 1'b0; m_b_pld  = '0; s_b_ready  = 1'b0;
        s_ar_valid = 1'b0; s_ar_pld = '0; m_ar_ready = 1'b0;
        m_r_valid  = 1'b0; m_r_pld  = '0; s_r_ready  = 1'b0;

        // Reset: registered slices idle and not ready; bypass AW still passes through.
        cyc();
        cyc();
        smp();
        chk("rst_w_ready", s_w_ready, 1'b0);
        chk("rst_ar_ready", s_ar_ready, 1'b0);
        chk("rst_b_ready", m_b_ready, 1'b0);
        chk("rst_r_ready", m_r_ready, 1'b0);
        chk("rst_w_valid", m_w_valid, 1'b0);
        chk("rst_ar_valid", m_ar_valid, 1'b0);
        chk("rst_b_valid", s_b_valid, 1'b0);
        chk("rst_r_valid", s_r_valid, 1'b0);
        aw_vec("aw_rst_a", 1'b1, 67'h5_DEAD_BEEF_0123_4567, 1'b1);
        aw_vec("aw_rst_b", 1'b0, 67'h2_1234_5678_9ABC_DEF0, 1'b0);

        // Release: first cycle after aresetn rises stays not-ready.
        cyc();
        aresetn = 1'b1;
        smp();
        chk("rel0_w_ready", s_w_ready, 1'b0);
        chk("rel0_ar_ready", s_ar_ready, 1'b0);
        chk("rel0_w_valid", m_w_valid, 1'b0);
        cyc();
        smp();
        chk("rel1_w_ready", s_w_ready, 1'b1);
        chk("rel1_ar_ready", s_ar_ready, 1'b1);
        chk("rel1_b_ready", m_b_ready, 1'b1);
        chk("rel1_r_ready", m_r_ready, 1'b1);
        chk("rel1_w_valid", m_w_valid, 1'b0);
        aw_vec("aw_run_a", 1'b1, 67'h7_FFFF_0000_FFFF_0000, 1'b0);

        // W streaming: 16 back-to-back beats, each visible one cycle after its accept.
        cyc();
        m_w_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_w_valid = 1'b1;
            s_w_pld   = wbeat(i);
            smp();
            chk("w_ready", s_w_ready, 1'b1);
            if (i > 0) begin
                chk("w_valid", m_w_valid, 1'b1);
                chk("w_pld", m_w_pld, wbeat(i - 1));
            end
            cyc();
        end
        s_w_valid = 1'b0;
        smp();
        chk("w_last_valid", m_w_valid, 1'b1);
        chk("w_last_pld", m_w_pld, wbeat(15));
        cyc();
        smp();
        chk("w_drained", m_w_valid, 1'b0);

        // R backpressure: upstream stalls for three cycles mid-burst.
        cyc();
        si = 0;
        for (int k = 0; k < 12; k++) begin
            m_r_valid = (si < 6);
            m_r_pld   = rbeat(si);
            s_r_ready = sr_rdy[k];
            smp();
            chk("r_mready", m_r_ready, exp_mrdy[k]);
            chk("r_svalid", s_r_valid, exp_oidx[k] >= 0);
            if (exp_oidx[k] >= 0) chk("r_spld", s_r_pld, rbeat(exp_oidx[k]));
            if (m_r_valid && m_r_ready) si++;
            cyc();
        end
        m_r_valid = 1'b0;
        chk("r_accepted", 128'(si), 128'd6);

        // AR forward slice: hold under backpressure, then pass-through accept.
        s_ar_valid = 1'b1;
        s_ar_pld   = arbeat(32'h1000);
        m_ar_ready = 1'b0;
        smp();
        chk("ar0_ready", s_ar_ready, 1'b1);
        chk("ar0_valid", m_ar_valid, 1'b0);
        cyc();
        s_ar_pld = arbeat(32'h2000);
        smp();
        chk("ar1_valid", m_ar_valid, 1'b1);
        chk("ar1_pld", m_ar_pld, arbeat(32'h1000));
        chk("ar1_ready", s_ar_ready, 1'b0);
        cyc();
        smp();
        chk("ar2_valid", m_ar_valid, 1'b1);
        chk("ar2_pld", m_ar_pld, arbeat(32'h1000));
        chk("ar2_ready", s_ar_ready, 1'b0);
        cyc();
        m_ar_ready = 1'b1;
        smp();
        chk("ar3_ready", s_ar_ready, 1'b1);
        chk("ar3_pld", m_ar_pld, arbeat(32'h1000));
        cyc();
        s_ar_valid = 1'b0;
        smp();
        chk("ar4_valid", m_ar_valid, 1'b1);
        chk("ar4_pld", m_ar_pld, arbeat(32'h2000));
        cyc();
        smp();
        chk("ar5_valid", m_ar_valid, 1'b0);

        // B: fill both entries, then reset for one cycle; nothing may be delivered.
        cyc();
        s_b_ready = 1'b0;
        m_b_valid = 1'b1;
        m_b_pld   = 7'h25;
        smp();
        chk("b0_ready", m_b_ready, 1'b1);
        cyc();
        m_b_pld = 7'h5A;
        smp();
        chk("b1_ready", m_b_ready, 1'b1);
        chk("b1_valid", s_b_valid, 1'b1);
        chk("b1_pld", s_b_pld, 7'h25);
        cyc();
        m_b_valid = 1'b0;
        aresetn   = 1'b0;
        smp();
        chk("b2_full_ready", m_b_ready, 1'b0);
        chk("b2_valid", s_b_valid, 1'b1);
        chk("b2_pld", s_b_pld, 7'h25);
        aw_vec("aw_rst_c", 1'b1, 67'h3_0F0F_F0F0_0F0F_F0F0, 1'b1);
        cyc();
        aresetn   = 1'b1;
        s_b_ready = 1'b1;
        smp();
        chk("b3_valid", s_b_valid, 1'b0);
        chk("b3_ready", m_b_ready, 1'b0);
        chk("b3_ar_ready", s_ar_ready, 1'b0);
        cyc();
        smp();
        chk("b4_valid", s_b_valid, 1'b0);
        chk("b4_ready", m_b_ready, 1'b1);
        chk("b4_ar_ready", s_ar_ready, 1'b1);
        cyc();
        smp();
        chk("b5_valid", s_b_valid, 1'b0);
        aw_vec("aw_run_b", 1'b0, 67'h0_0000_0001_0000_0001, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_reg_slice.md
AXI_REG_SLICE -- requirements
Module: axi_reg_slice

Interface
REQ-001 SHALL have parameters:
- ID_W, default 4, AXI ID width on all channels.
- ADDR_W, default 32, AW/AR address width.
- DATA_W, default 64, W/R data width; WSTRB width is DATA_W/8.
- USER_W, default 1, user width on all channels.
- AW_MODE, default 2, slice mode for AW; 0=bypass, 1=forward, 2=full.
- W_MODE, default 2, slice mode for W.
- B_MODE, default 2, slice mode for B.
- AR_MODE, default 2, slice mode for AR.
- R_MODE, default 2, slice mode for R.

REQ-002 SHALL have ports (s_ faces upstream master, m_ faces downstream slave):
- aclk  in  1  sole clock, rising edge.
- aresetn  in  1  reset, synchronous, active-low.
- s_aw_valid/s_aw_ready/s_aw_pld  in/out/in  1/1/AWP  upstream AW; AWP = ID_W+ADDR_W+8+3+2+2+4+3+4+4+USER_W, packed {id,addr,len,size,burst,lock,cache,prot,qos,region,user}.
- m_aw_valid/m_aw_ready/m_aw_pld  out/in/out  1/1/AWP  downstream AW.
- s_w_valid/s_w_ready/s_w_pld  in/out/in  1/1/WP  upstream W; WP = ID_W+DATA_W+DATA_W/8+USER_W+1, packed {id,data,strb,user,last}.
- m_w_valid/m_w_ready/m_w_pld  out/in/out  1/1/WP  downstream W.
- m_b_valid/m_b_ready/m_b_pld  in/out/in  1/1/BP  downstream B; BP = ID_W+2+USER_W, packed {id,resp,user}.
- s_b_valid/s_b_ready/s_b_pld  out/in/out  1/1/BP  upstream B.
- s_ar_valid/s_ar_ready/s_ar_pld  in/out/in  1/1/AWP  upstream AR, same packing as AW.
- m_ar_valid/m_ar_ready/m_ar_pld  out/in/out  1/1/AWP  downstream AR.
- m_r_valid/m_r_ready/m_r_pld  in/out/in  1/1/RP  downstream R; RP = ID_W+DATA_W+2+USER_W+1, packed {id,data,resp,user,last}.
- s_r_valid/s_r_ready/s_r_pld  out/in/out  1/1/RP  upstream R.

Function
REQ-003 Each channel SHALL be an independent slice from its input side (in_valid/in_ready/in_pld) to its output side (out_valid/out_ready/out_pld), configured by its *_MODE.
- Input side: s_ for AW/W/AR, m_ for B/R.
- No cross-channel interaction.

REQ-004 Mode 0 (bypass):
- out_valid = in_valid, out_pld = in_pld, in_ready = out_ready, all combinational.
- Latency 0; no state.

REQ-005 Mode 1 (forward):
- out_valid and out_pld are registered.
- in_ready = rst_done && (!out_valid || out_ready), combinational.
- Latency 1 cycle; sustains 1 beat per cycle with no bubbles.

REQ-006 Mode 2 (full):
- Two-entry skid buffer; in_ready and out_valid both driven directly from flops, with no combinational in->out path on any signal.
- Latency 1 cycle; sustains 1 beat per cycle.

REQ-007 Mode 2 state machine, states EMPTY, ONE, TWO (in = in_valid&&in_ready, out = out_valid&&out_ready):
- EMPTY: in -> ONE.
- ONE: in && !out -> TWO; !in && out -> EMPTY; in && out -> stays ONE, main register loads the new beat.
- TWO: out -> ONE, skid entry moves to the main register; in cannot occur.

REQ-008 Mode 2 outputs per state:
- out_valid = (state != EMPTY).
- in_ready = rst_done && (state != TWO), registered.

REQ-009 Beat order SHALL be preserved in every mode; no beat duplicated or dropped.

REQ-010 While out_valid && !out_ready, out_pld SHALL hold stable and out_valid SHALL stay 1.

REQ-011 Payload flops are not reset. Payload SHALL only be sampled when its valid is 1.

REQ-012 A *_MODE value outside 0..2 SHALL produce an elaboration error.

Reset
REQ-013 aresetn low at a rising edge SHALL, on that edge:
- Force all registered out_valid to 0.
- Force all mode-2 states to EMPTY.
- Clear rst_done.
- Discard any buffered beats, including on reset asserted mid-burst.

REQ-014 rst_done SHALL set on the first rising edge with aresetn high. Consequently, in modes 1 and 2, in_ready is 0 during reset and for the first cycle after release, and is 1 from the second cycle.

REQ-015 In mode 0, reset SHALL have no effect on that channel.

Verification
REQ-016 Reset release, all modes 2: s_aw_ready = 0 in the cycle aresetn rises, 1 the next cycle; all m_*_valid = 0 throughout.

REQ-017 Streaming, W_MODE=2: 16 back-to-back W beats with m_w_ready held 1 -> m_w_pld carries beats 0..15 on 16 consecutive cycles, starting 1 cycle after the first accept.

REQ-018 Backpressure, R_MODE=2: m_r_ready held 1, s_r_ready driven 0 for 3 cycles during a burst ->
- Exactly 2 beats buffered, then m_r_ready = 0.
- s_r_pld stable over the stall.
- After release, all beats arrive in order with last on the final beat.

REQ-019 Mode 1, AR: s_ar_valid=1 with addr 0x1000 while m_ar_ready = 0 -> m_ar_valid rises next cycle and holds with addr 0x1000. s_ar_ready = 0 until m_ar_ready = 1, then a new beat is accepted in the same cycle.

REQ-020 Mid-operation reset, B_MODE=2, state TWO: assert aresetn = 0 for 1 cycle -> s_b_valid = 0 next cycle; the two held responses are never delivered.

REQ-021 Mode 0, AW: s_aw_* and m_aw_* are combinationally equal in every cycle, including while aresetn = 0.
